// File: rtl/alu_mc_pkg.sv
// ============================================================================
// Module : alu_mc_pkg
// Brief  : Opcode map and FSM state encoding shared by the multi-cycle ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_mc_pkg;

   localparam int OP_WIDTH = 4;

   // Legacy 3-bit opcodes occupy 0..7 unchanged; extensions live in 8..C.
   localparam logic [OP_WIDTH-1:0] OP_HLT = 4'h0;
   localparam logic [OP_WIDTH-1:0] OP_SKZ = 4'h1;
   localparam logic [OP_WIDTH-1:0] OP_ADD = 4'h2;
   localparam logic [OP_WIDTH-1:0] OP_AND = 4'h3;
   localparam logic [OP_WIDTH-1:0] OP_XOR = 4'h4;
   localparam logic [OP_WIDTH-1:0] OP_LDA = 4'h5;
   localparam logic [OP_WIDTH-1:0] OP_STO = 4'h6;
   localparam logic [OP_WIDTH-1:0] OP_JMP = 4'h7;
   localparam logic [OP_WIDTH-1:0] OP_SUB = 4'h8;
   localparam logic [OP_WIDTH-1:0] OP_OR  = 4'h9;
   localparam logic [OP_WIDTH-1:0] OP_SHL = 4'hA;
   localparam logic [OP_WIDTH-1:0] OP_SHR = 4'hB;
   localparam logic [OP_WIDTH-1:0] OP_MUL = 4'hC;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// ============================================================================
// Module : alu_mul_iter
// Brief  : Iterative shift-add multiplier, one partial product per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mul_iter
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_a;
   logic [WIDTH-1:0]   r_b;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;

   logic [2*WIDTH-1:0] w_next;
   logic               w_last;

   assign w_next = r_acc + (r_b[0] ? r_a : '0);
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // done and prod describe the final iteration combinationally so the
   // consumer can register the result on the same edge that ends busy.
   assign busy = r_busy;
   assign done = r_busy && w_last;
   assign prod = w_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_a    <= '0;
         r_b    <= '0;
      end else if (start && !r_busy) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_acc  <= '0;
         r_a    <= {{WIDTH{1'b0}}, a};
         r_b    <= b;
      end else if (r_busy) begin
         r_acc  <= w_next;
         r_a    <= r_a << 1;
         r_b    <= r_b >> 1;
         r_cnt  <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_mc_cpu.sv
// ============================================================================
// Module : alu_mc_cpu
// Brief  : Parametrised multi-cycle ALU with start/busy/done handshake.
//          Define ALU_MUL_EN to build the iterative multiplier for opcode C.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mc_cpu
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OP_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              con_alu,
   input  logic [OP_W-1:0]   opcode,
   input  logic [WIDTH-1:0]  data,
   input  logic [WIDTH-1:0]  accum,
   output logic [WIDTH-1:0]  alu_out,
   output logic              zero,
   output logic              carry,
   output logic              neg,
   output logic              busy,
   output logic              done
);

`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic [WIDTH-1:0]   r_alu_out;
   logic               r_carry;
   logic               r_neg;
   logic               r_done;

   logic [WIDTH-1:0]   w_res;
   logic               w_cy;
   logic               w_is_mul;
   logic               w_accept;
   logic               w_single;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_mul_prod;

   assign zero     = (accum == '0);
   assign w_is_mul = MUL_EN && (opcode == OP_MUL);
   assign w_accept = con_alu && !busy;
   assign w_single = w_accept && !w_is_mul;

   // Single-cycle decode; anything not matched (incl. reserved D-F) passes accum.
   always_comb begin
      w_res = accum;
      w_cy  = 1'b0;
      case (opcode)
         OP_ADD: {w_cy, w_res} = {1'b0, accum} + {1'b0, data};
         OP_SUB: {w_cy, w_res} = {1'b0, accum} - {1'b0, data};
         OP_AND: w_res = accum & data;
         OP_XOR: w_res = accum ^ data;
         OP_OR:  w_res = accum | data;
         OP_LDA: w_res = data;
         OP_SHL: {w_cy, w_res} = {accum, 1'b0};
         OP_SHR: {w_res, w_cy} = {1'b0, accum};
         default: ;
      endcase
   end

`ifdef ALU_MUL_EN
   alu_state_t r_state;
   alu_state_t w_state_nxt;
   logic       w_mul_start;
   logic       w_mul_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mul_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (con_alu && w_is_mul) begin
               w_mul_start = 1'b1;
               w_state_nxt = ST_MUL;
            end
         end
         ST_MUL: begin
            // Leaving on !busy as well keeps the FSM from sticking if the
            // multiplier ever drops busy without a done.
            if (w_mul_done || !w_mul_busy) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (r_state == ST_MUL);

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (w_mul_start),
      .a     (accum),
      .b     (data),
      .busy  (w_mul_busy),
      .done  (w_mul_done),
      .prod  (w_mul_prod)
   );
`else
   assign busy       = 1'b0;
   assign w_mul_done = 1'b0;
   assign w_mul_prod = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_out <= '0;
         r_carry   <= 1'b0;
         r_neg     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_mul_done) begin
            r_alu_out <= w_mul_prod[WIDTH-1:0];
            r_carry   <= |w_mul_prod[2*WIDTH-1:WIDTH];
            r_neg     <= w_mul_prod[WIDTH-1];
            r_done    <= 1'b1;
         end else if (w_single) begin
            r_alu_out <= w_res;
            r_carry   <= w_cy;
            r_neg     <= w_res[WIDTH-1];
            r_done    <= 1'b1;
         end
      end
   end

   assign alu_out = r_alu_out;
   assign carry   = r_carry;
   assign neg     = r_neg;
   assign done    = r_done;

endmodule

`default_nettype wire
